// File: rtl/idu1_scoreboard_pkg.sv
// Shared constants and helpers for the IDU1 register-hazard scoreboard.
package idu1_scoreboard_pkg;

    localparam int unsigned NUM_REGS            = 32;
    localparam int unsigned REG_FILE_ADDR_WIDTH = 5;
    localparam int unsigned ADDR_W              = REG_FILE_ADDR_WIDTH;
    localparam int unsigned MAX_OUTSTANDING     = 4;
    localparam int unsigned CNT_W               = $clog2(MAX_OUTSTANDING + 1);

    // One-hot decode of a register address; x0 decodes to an empty vector.
    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] vec;
        vec = NUM_REGS'(1) << addr;
        vec[0] = 1'b0;
        return vec;
    endfunction

endpackage

// File: rtl/idu1_scoreboard.sv
// Register-hazard scoreboard: tracks destinations of in-flight long ops (MUL/DIV/LOAD)
// and stalls IDU1 on RAW/WAW hazards or when the in-flight budget is exhausted.
module idu1_scoreboard
    import idu1_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rs1_addr,
    input  logic                issue_rs1_rd_en,
    input  logic [ADDR_W-1:0]   issue_rs2_addr,
    input  logic                issue_rs2_rd_en,
    input  logic [ADDR_W-1:0]   issue_rd_addr,
    input  logic                issue_rd_wr_en,
    input  logic                issue_long,
    input  logic [ADDR_W-1:0]   wb_rd_addr,
    input  logic                wb_rd_wr_en,
    output logic                sb_stall,
    output logic                issue_accept,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [CNT_W-1:0]    outstanding_cnt
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_REGS-1:0] clr_vec, set_vec, eff_mask;
    logic                raw1, raw2, waw, full;
    logic                inc, dec;

    // Hazard view with same-cycle writeback bypass; x0 never hazards.
    always_comb begin
        clr_vec  = wb_rd_wr_en ? addr_onehot(wb_rd_addr) : '0;
        eff_mask = pending_q & ~clr_vec;
        eff_mask[0] = 1'b0;

        dec  = wb_rd_wr_en & pending_q[wb_rd_addr];
        raw1 = issue_rs1_rd_en & eff_mask[issue_rs1_addr];
        raw2 = issue_rs2_rd_en & eff_mask[issue_rs2_addr];
        waw  = issue_rd_wr_en  & eff_mask[issue_rd_addr];
        full = issue_long & issue_rd_wr_en
             & (cnt_q == CNT_W'(MAX_OUTSTANDING)) & ~dec;

        sb_stall     = issue_valid & (raw1 | raw2 | waw | full);
        issue_accept = issue_valid & ~sb_stall;
    end

    // Next state: clear on writeback, then set for the new producer so a tie hands ownership over.
    always_comb begin
        inc     = issue_accept & issue_long & issue_rd_wr_en & (issue_rd_addr != '0);
        set_vec = inc ? addr_onehot(issue_rd_addr) : '0;

        pending_d    = (pending_q & ~clr_vec) | set_vec;
        pending_d[0] = 1'b0;

        cnt_d = cnt_q;
        case ({inc, dec})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_mask    = pending_q;
    assign outstanding_cnt = cnt_q;

    // The counter must always mirror the pending vector and stay within budget.
    a_cnt_matches_mask: assert property (@(posedge clk) disable iff (!rstn)
        (32'(cnt_q) == 32'($countones(pending_q))) && (32'(cnt_q) <= MAX_OUTSTANDING));

    a_no_dec_at_zero: assert property (@(posedge clk) disable iff (!rstn)
        !(dec && (cnt_q == '0)));

    a_x0_never_pending: assert property (@(posedge clk) disable iff (!rstn)
        !pending_q[0]);

endmodule

// File: tb/tb_idu1_scoreboard.sv
// Directed bench for idu1_scoreboard: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_idu1_scoreboard;
    import idu1_scoreboard_pkg::*;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                issue_valid = 1'b0;
    logic [ADDR_W-1:0]   issue_rs1_addr = '0;
    logic                issue_rs1_rd_en = 1'b0;
    logic [ADDR_W-1:0]   issue_rs2_addr = '0;
    logic                issue_rs2_rd_en = 1'b0;
    logic [ADDR_W-1:0]   issue_rd_addr = '0;
    logic                issue_rd_wr_en = 1'b0;
    logic                issue_long = 1'b0;
    logic [ADDR_W-1:0]   wb_rd_addr = '0;
    logic                wb_rd_wr_en = 1'b0;
    logic                sb_stall;
    logic                issue_accept;
    logic [NUM_REGS-1:0] pending_mask;
    logic [CNT_W-1:0]    outstanding_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic                stall;
        logic                acc;
        logic [NUM_REGS-1:0] mask;
        logic [CNT_W-1:0]    cnt;
        string               nm;
    } exp_t;

    exp_t exp_q[$];

    idu1_scoreboard dut (
        .clk             (clk),
        .rstn            (rstn),
        .issue_valid     (issue_valid),
        .issue_rs1_addr  (issue_rs1_addr),
        .issue_rs1_rd_en (issue_rs1_rd_en),
        .issue_rs2_addr  (issue_rs2_addr),
        .issue_rs2_rd_en (issue_rs2_rd_en),
        .issue_rd_addr   (issue_rd_addr),
        .issue_rd_wr_en  (issue_rd_wr_en),
        .issue_long      (issue_long),
        .wb_rd_addr      (wb_rd_addr),
        .wb_rd_wr_en     (wb_rd_wr_en),
        .sb_stall        (sb_stall),
        .issue_accept    (issue_accept),
        .pending_mask    (pending_mask),
        .outstanding_cnt (outstanding_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (sb_stall !== e.stall) begin
                errors++;
                $display("FAIL %s.stall got %0b want %0b", e.nm, sb_stall, e.stall);
            end
            checks++;
            if (issue_accept !== e.acc) begin
                errors++;
                $display("FAIL %s.accept got %0b want %0b", e.nm, issue_accept, e.acc);
            end
            checks++;
            if (pending_mask !== e.mask) begin
                errors++;
                $display("FAIL %s.mask got %08h want %08h", e.nm, pending_mask, e.mask);
            end
            checks++;
            if (outstanding_cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s.cnt got %0d want %0d", e.nm, outstanding_cnt, e.cnt);
            end
        end
    end

    // One cycle of stimulus plus the hand-computed response for that cycle.
    task automatic cyc(
        input logic rst_v, input logic v,
        input logic [ADDR_W-1:0] rs1, input logic e1,
        input logic [ADDR_W-1:0] rs2, input logic e2,
        input logic [ADDR_W-1:0] rd,  input logic ed, input logic lng,
        input logic [ADDR_W-1:0] wa,  input logic we,
        input logic xs, input logic xa,
        input logic [NUM_REGS-1:0] xm, input logic [CNT_W-1:0] xc,
        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rstn            = rst_v;
        issue_valid     = v;
        issue_rs1_addr  = rs1;
        issue_rs1_rd_en = e1;
        issue_rs2_addr  = rs2;
        issue_rs2_rd_en = e2;
        issue_rd_addr   = rd;
        issue_rd_wr_en  = ed;
        issue_long      = lng;
        wb_rd_addr      = wa;
        wb_rd_wr_en     = we;
        e.stall = xs;
        e.acc   = xa;
        e.mask  = xm;
        e.cnt   = xc;
        e.nm    = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        repeat (2) @(posedge clk);

        //   rst v  rs1 e1 rs2 e2 rd e  lng wa we  stall acc mask           cnt
        // Reset: async clear of a live pending bit
        cyc(1, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0,  0, 1, 32'h0000_0000, 0, "rst_mul2");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0000_0004, 1, "rst_pre");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0000_0000, 0, "rst_async");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0000_0000, 0, "rst_post");
        // RAW on rs1 with writeback bypass
        cyc(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0,  0, 1, 32'h0000_0000, 0, "raw_mul5");
        cyc(1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0,  1, 0, 32'h0000_0020, 1, "raw_stall1");
        cyc(1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0,  1, 0, 32'h0000_0020, 1, "raw_stall2");
        cyc(1, 1, 5, 1, 0, 0, 6, 1, 0, 5, 1,  0, 1, 32'h0000_0020, 1, "raw_bypass");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0000_0000, 0, "raw_clear");
        // WAW tie: writeback and new producer on rd=7 in one cycle
        cyc(1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,  0, 1, 32'h0000_0000, 0, "tie_load7");
        cyc(1, 1, 0, 0, 0, 0, 7, 1, 1, 7, 1,  0, 1, 32'h0000_0080, 1, "tie_div7");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0000_0080, 1, "tie_owned");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 1,  0, 0, 32'h0000_0080, 1, "tie_wb7");
        // Full: four in flight, fifth admitted by same-cycle free
        cyc(1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0,  0, 1, 32'h0000_0000, 0, "full_mul1");
        cyc(1, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0,  0, 1, 32'h0000_0002, 1, "full_mul2");
        cyc(1, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0,  0, 1, 32'h0000_0006, 2, "full_mul3");
        cyc(1, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0,  0, 1, 32'h0000_000E, 3, "full_mul4");
        cyc(1, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0,  1, 0, 32'h0000_001E, 4, "full_stall1");
        cyc(1, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0,  1, 0, 32'h0000_001E, 4, "full_stall2");
        cyc(1, 1, 0, 0, 0, 0, 9, 1, 1, 2, 1,  0, 1, 32'h0000_001E, 4, "full_free");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0000_021A, 4, "full_after");
        // Drain, probing WAW on an ALU op and RAW on rs2 along the way
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 32'h0000_021A, 4, "drain_wb1");
        cyc(1, 1, 0, 0, 0, 0, 4, 1, 0, 3, 1,  1, 0, 32'h0000_0218, 3, "waw_alu4");
        cyc(1, 1, 0, 0, 9, 1, 6, 1, 0, 4, 1,  1, 0, 32'h0000_0210, 2, "raw2_rs9");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 1,  0, 0, 32'h0000_0200, 1, "drain_wb9");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0000_0000, 0, "drain_done");
        // x0 destination and store-like long op are not tracked
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0,  0, 1, 32'h0000_0000, 0, "x0_mul");
        cyc(1, 1, 0, 0, 0, 0, 8, 0, 1, 0, 0,  0, 1, 32'h0000_0000, 0, "store_load");
        cyc(1, 1, 0, 1, 0, 1, 10, 1, 0, 0, 0, 0, 1, 32'h0000_0000, 0, "x0_read");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0000_0000, 0, "x0_idle");
        // ALU writeback to a non-pending register is a no-op
        cyc(1, 1, 0, 0, 0, 0, 13, 1, 1, 0, 0, 0, 1, 32'h0000_0000, 0, "alu_mul13");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 12, 1, 0, 0, 32'h0000_2000, 1, "alu_wb12");
        cyc(1, 0, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_2000, 1, "novalid_hz");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 13, 1, 0, 0, 32'h0000_2000, 1, "alu_wb13");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0000_0000, 0, "alu_done");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d queued want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
